timer_dev: RTL

TIMER_DEV -- requirements
Module: timer_dev

---
 rtl/timer_dev_pkg.sv | 35 +++
 rtl/timer_wmerge.sv | 21 ++
 rtl/timer_dev.sv | 120 ++++++++++++
 3 files changed

// File: rtl/timer_dev_pkg.sv
// rtl/timer_dev_pkg.sv - shared register map, CTRL fields, MODE codes and FSM states
// Purpose: constants and types shared by timer_dev and its bench.
// Ports: none (package).
package timer_dev_pkg;

  // Register word offsets (processor address bits [3:2])
  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;
  localparam logic [1:0] ADDR_RSVD   = 2'b11;

  // CTRL bit positions
  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_W       = 4;

  // MODE encodings
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } state_t;

  // Only 01 selects auto-reload; every other code behaves as one-shot.
  function automatic logic [1:0] eff_mode(input logic [1:0] mode);
    return (mode == MODE_AUTO) ? MODE_AUTO : MODE_ONESHOT;
  endfunction

endpackage

// File: rtl/timer_wmerge.sv
// rtl/timer_wmerge.sv - combinational byte-enable write merge
// Purpose: new = old with each byte lane i replaced by din lane i when be[i]=1.
// Ports: i_old (current value), i_din (write data), i_be (byte enables),
//        o_new (merged value).
module timer_wmerge (
  input  logic [31:0] i_old,
  input  logic [31:0] i_din,
  input  logic [3:0]  i_be,
  output logic [31:0] o_new
);

  always_comb begin
    o_new = i_old;
    for (int i = 0; i < 4; i++) begin
      if (i_be[i]) begin
        o_new[8*i +: 8] = i_din[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/timer_dev.sv
// rtl/timer_dev.sv - bus-mapped down-counting timer with one-shot/auto-reload IRQ
// Purpose: CTRL/PRESET/COUNT register block driving a 4-state count FSM.
// Ports: clk (clock), rst (sync active-low reset), sel/addr/wen/be/din (write
//        port), dout (combinational read data), irq (IM AND pend).
module timer_dev #(
  parameter int CNT_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        wen,
  input  logic [3:0]  be,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  import timer_dev_pkg::*;

  logic [CTRL_W-1:0] r_ctrl;
  logic [CNT_W-1:0]  r_preset;
  logic [CNT_W-1:0]  r_count;
  logic              r_pend;
  state_t            r_state;

  logic        w_wr_ctrl;
  logic        w_wr_preset;
  logic        w_auto;
  logic [31:0] w_ctrl_new;
  logic [31:0] w_preset_new;
  logic        w_unused_merge;

  assign w_wr_ctrl   = sel && wen && (addr == ADDR_CTRL);
  assign w_wr_preset = sel && wen && (addr == ADDR_PRESET);
  assign w_auto      = (eff_mode(r_ctrl[CTRL_MODE_HI:CTRL_MODE_LO]) == MODE_AUTO);

  timer_wmerge u_ctrl_merge (
    .i_old (32'(r_ctrl)),
    .i_din (din),
    .i_be  (be),
    .o_new (w_ctrl_new)
  );

  timer_wmerge u_preset_merge (
    .i_old (32'(r_preset)),
    .i_din (din),
    .i_be  (be),
    .o_new (w_preset_new)
  );

  // Merge outputs are 32 bits wide; only the low register-width bits are stored.
  assign w_unused_merge = &{1'b0, w_ctrl_new, w_preset_new};

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_pend   <= 1'b0;
      r_state  <= ST_IDLE;
    end else begin
      if (w_wr_ctrl) begin
        r_ctrl <= w_ctrl_new[CTRL_W-1:0];
        r_pend <= 1'b0;
      end
      if (w_wr_preset) begin
        r_preset <= w_preset_new[CNT_W-1:0];
      end

      // FSM assignments come after the bus write so that INT entry (pend set)
      // and the one-shot EN clear take precedence on a coincident edge.
      case (r_state)
        ST_IDLE: begin
          if (r_ctrl[CTRL_EN]) begin
            r_state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          r_count <= r_preset;
          r_state <= ST_CNT;
        end
        ST_CNT: begin
          if (!r_ctrl[CTRL_EN]) begin
            r_state <= ST_IDLE;
          end else if (r_count == '0) begin
            r_state <= ST_INT;
            r_pend  <= 1'b1;
          end else begin
            r_count <= r_count - CNT_W'(1);
          end
        end
        ST_INT: begin
          if (w_auto) begin
            r_state <= ST_LOAD;
            r_pend  <= 1'b0;
          end else begin
            r_ctrl[CTRL_EN] <= 1'b0;
            r_state         <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      ADDR_CTRL:   dout = 32'(r_ctrl);
      ADDR_PRESET: dout = 32'(r_preset);
      ADDR_COUNT:  dout = 32'(r_count);
      ADDR_RSVD:   dout = '0;
      default:     dout = '0;
    endcase
  end

  assign irq = r_ctrl[CTRL_IM] & r_pend;

endmodule
